// File: rtl/tape_ram_writer.sv
// Commits bytes streamed by the cassette TAP parser into main RAM over a shared
// request/grant port, then hands the execution address to the boot logic.
module tape_ram_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tape_wr,
  input  logic [ADDR_W-1:0] tape_addr,
  input  logic [7:0]        tape_dout,
  input  logic              tape_complete,
  output logic              ram_req,
  input  logic              ram_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              ram_we,
  output logic              busy,
  output logic              exec_valid,
  output logic [ADDR_W-1:0] exec_addr,
  input  logic              exec_ack,
  output logic [15:0]       byte_count,
  output logic [7:0]        checksum,
  output logic              overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = ADDR_W + 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
  logic                tape_wr_q;
  logic [ADDR_W-1:0]   tape_addr_q;
  logic                tape_complete_q;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]          ram_dout_q, ram_dout_d;
  logic [ADDR_W-1:0]   exec_addr_q, exec_addr_d;
  logic                complete_pend_q, complete_pend_d;
  logic [15:0]         byte_count_q, byte_count_d;
  logic [7:0]          checksum_q, checksum_d;
  logic                overflow_q, overflow_d;

  logic [PTR_W:0]      occupancy;
  logic [PTR_W:0]      rd_ptr_nx;
  logic                fifo_empty;
  logic                fifo_full;
  logic                capture;
  logic                push;
  logic                pop;
  logic                complete_rise;
  logic                complete_fall;
  logic                exec_taken;

  assign occupancy     = wr_ptr_q - rd_ptr_q;
  assign rd_ptr_nx     = rd_ptr_q + (PTR_W+1)'(1);
  assign fifo_empty    = (wr_ptr_q == rd_ptr_q);
  assign fifo_full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                         (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  // A new byte is a rising write level or an address step while the level is held.
  assign capture       = tape_wr && (!tape_wr_q || (tape_addr != tape_addr_q));
  assign pop           = (state_q == S_WRITE);
  assign push          = capture && (!fifo_full || pop);
  assign complete_rise = tape_complete && !tape_complete_q;
  assign complete_fall = !tape_complete && tape_complete_q;

  // NOTE: every signal assigned in an always_comb gets a default on the first lines,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    state_d    = state_q;
    ram_addr_d = ram_addr_q;
    ram_dout_d = ram_dout_q;
    ram_req    = 1'b0;
    ram_we     = 1'b0;
    exec_valid = 1'b0;
    exec_taken = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d                  = S_REQ;
          {ram_addr_d, ram_dout_d} = mem[rd_ptr_q[PTR_W-1:0]];
        end else if (complete_pend_q) begin
          state_d = S_DONE;
        end
      end
      S_REQ: begin
        ram_req = 1'b1;
        if (ram_gnt) state_d = S_WRITE;
      end
      S_WRITE: begin
        ram_req = 1'b1;
        ram_we  = 1'b1;
        if (occupancy > (PTR_W+1)'(1)) begin
          state_d                  = S_REQ;
          {ram_addr_d, ram_dout_d} = mem[rd_ptr_nx[PTR_W-1:0]];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        exec_valid = 1'b1;
        if (exec_ack) begin
          state_d    = S_IDLE;
          exec_taken = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d        = push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
    rd_ptr_d        = pop ? rd_ptr_nx : rd_ptr_q;
    overflow_d      = overflow_q | (capture && !push);
    complete_pend_d = complete_pend_q;
    exec_addr_d     = exec_addr_q;
    byte_count_d    = byte_count_q;
    checksum_d      = checksum_q;
    if (exec_taken) complete_pend_d = 1'b0;
    if (complete_rise && (state_q != S_DONE)) begin
      complete_pend_d = 1'b1;
      exec_addr_d     = tape_addr;
    end
    // Start of a new load wins over a byte committed on the same edge.
    if (complete_fall) begin
      byte_count_d = 16'd0;
      checksum_d   = 8'd0;
    end else if (pop) begin
      byte_count_d = byte_count_q + 16'd1;
      checksum_d   = checksum_q + ram_dout_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      tape_wr_q       <= 1'b0;
      tape_addr_q     <= '0;
      tape_complete_q <= 1'b0;
      ram_addr_q      <= '0;
      ram_dout_q      <= '0;
      exec_addr_q     <= '0;
      complete_pend_q <= 1'b0;
      byte_count_q    <= '0;
      checksum_q      <= '0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      tape_wr_q       <= tape_wr;
      tape_addr_q     <= tape_addr;
      tape_complete_q <= tape_complete;
      ram_addr_q      <= ram_addr_d;
      ram_dout_q      <= ram_dout_d;
      exec_addr_q     <= exec_addr_d;
      complete_pend_q <= complete_pend_d;
      byte_count_q    <= byte_count_d;
      checksum_q      <= checksum_d;
      overflow_q      <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers define which entries are valid,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[PTR_W-1:0]] <= {tape_addr, tape_dout};
  end

  assign ram_addr   = ram_addr_q;
  assign ram_dout   = ram_dout_q;
  assign exec_addr  = exec_addr_q;
  assign byte_count = byte_count_q;
  assign checksum   = checksum_q;
  assign overflow   = overflow_q;
  assign busy       = !fifo_empty || (state_q != S_IDLE) || complete_pend_q;

endmodule

// File: tb/tb_tape_ram_writer.sv
// Self-checking bench for tape_ram_writer: a queue of expected RAM writes is
// filled from the stimulus and drained by a write monitor.
module tb_tape_ram_writer;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        exp_cap;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tape_wr, tape_complete, ram_gnt, exec_ack;
  logic [15:0] tape_addr;
  logic [7:0]  tape_dout;
  logic        ram_req, ram_we, busy, exec_valid, overflow;
  logic [15:0] ram_addr, exec_addr, byte_count;
  logic [7:0]  ram_dout, checksum;

  int          n_checks = 0;
  int          n_err    = 0;
  int          wr_seen  = 0;
  int          cyc      = 0;
  int          wr_cyc[$];
  wr_t         exp_q[$];
  int          model_count;
  logic [7:0]  model_sum;
  logic        prev_wr;
  logic [15:0] prev_addr;
  vec_t        tbl[16];

  tape_ram_writer #(.FIFO_DEPTH(16), .ADDR_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .tape_wr(tape_wr), .tape_addr(tape_addr), .tape_dout(tape_dout),
    .tape_complete(tape_complete),
    .ram_req(ram_req), .ram_gnt(ram_gnt), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .ram_we(ram_we),
    .busy(busy), .exec_valid(exec_valid), .exec_addr(exec_addr), .exec_ack(exec_ack),
    .byte_count(byte_count), .checksum(checksum), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every ram_we pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && ram_we === 1'b1) begin
      wr_seen++;
      wr_cyc.push_back(cyc);
      check("wr_req_high", ram_req, 1);
      check("wr_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check("wr_addr", ram_addr, exp_q[0].addr);
        check("wr_data", ram_dout, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic expect_write(input logic [15:0] addr, input logic [7:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
    model_count++;
    model_sum += data;
  endtask

  task automatic step(input logic wr, input logic [15:0] addr, input logic [7:0] data,
                      input logic gnt, input logic comp, input logic push);
    tape_wr       = wr;
    tape_addr     = addr;
    tape_dout     = data;
    ram_gnt       = gnt;
    tape_complete = comp;
    if (push) expect_write(addr, data);
    prev_wr   = wr;
    prev_addr = addr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    tape_wr       = 1'b0;
    tape_addr     = '0;
    tape_dout     = '0;
    tape_complete = 1'b0;
    ram_gnt       = 1'b0;
    exec_ack      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    wr_cyc.delete();
    model_count = 0;
    model_sum   = 8'd0;
    prev_wr     = 1'b0;
    prev_addr   = '0;
    wr_seen     = 0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    check({tag, "_drain"}, done, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {ram_req, ram_we, busy, exec_valid, overflow}, 0);
    check({tag, "_ram"}, {ram_addr, ram_dout}, 0);
    check({tag, "_exec_addr"}, exec_addr, 0);
    check({tag, "_stats"}, {byte_count, checksum}, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  len, captured, guard, base;
    bit  seen;
    logic        wr, gnt, cap;
    logic [15:0] addr;
    logic [7:0]  data;

    // Reset state
    reset_n = 1'b0;
    tape_wr = 1'b0; tape_addr = '0; tape_dout = '0; tape_complete = 1'b0;
    ram_gnt = 1'b0; exec_ack = 1'b0;
    #3;
    check_all_zero("in_reset");
    do_reset();
    check_all_zero("after_reset");

    // Four consecutive bytes, grant always high: one write every two cycles
    step(1, 16'h694D, 8'h11, 1, 0, 1);
    step(1, 16'h694E, 8'h22, 1, 0, 1);
    step(1, 16'h694F, 8'h33, 1, 0, 1);
    step(1, 16'h6950, 8'h44, 1, 0, 1);
    step(0, 16'h6950, 8'h00, 1, 0, 0);
    wait_drain(40, "basic");
    check("basic_writes", wr_seen, 4);
    check("basic_count", byte_count, 16'd4);
    check("basic_checksum", checksum, 8'hAA);
    if (wr_cyc.size() == 4)
      for (int i = 1; i < 4; i++) check("basic_gap", wr_cyc[i] - wr_cyc[i-1], 2);

    // Table-driven capture rule: held level, re-arm, address step while held
    do_reset();
    tbl[0] = '{1'b1, 16'h1234, 8'h5A, 1'b1};
    for (int i = 1; i < 10; i++) tbl[i] = '{1'b1, 16'h1234, 8'(8'h60 + i), 1'b0};
    tbl[10] = '{1'b0, 16'h1234, 8'h00, 1'b0};
    tbl[11] = '{1'b1, 16'h1234, 8'hA5, 1'b1};
    tbl[12] = '{1'b1, 16'h1235, 8'h3C, 1'b1};
    tbl[13] = '{1'b1, 16'h1235, 8'hC3, 1'b0};
    tbl[14] = '{1'b0, 16'h1235, 8'h00, 1'b0};
    tbl[15] = '{1'b1, 16'h1235, 8'h0F, 1'b1};
    for (int i = 0; i < 16; i++) step(tbl[i].wr, tbl[i].addr, tbl[i].data, 1, 0, tbl[i].exp_cap);
    step(0, 16'h1235, 8'h00, 1, 0, 0);
    wait_drain(60, "table");
    check("table_writes", wr_seen, model_count);
    check("table_count", byte_count, model_count);
    check("table_checksum", checksum, model_sum);

    // Overflow: grant withheld for 40 cycles while 20 bytes arrive
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1, 16'h8000 + 16'(i), 8'(i * 7 + 3), 0, 0, i < 16);
    for (int i = 0; i < 20; i++) step(0, 16'h8013, 8'h00, 0, 0, 0);
    check("ovf_no_write_wo_gnt", wr_seen, 0);
    check("ovf_req_held", ram_req, 1);
    check("ovf_flag", overflow, 1);
    ram_gnt = 1'b1;
    wait_drain(80, "ovf");
    check("ovf_writes", wr_seen, 16);
    check("ovf_count", byte_count, 16'd16);
    check("ovf_sticky", overflow, 1);

    // Full FIFO: push accepted on the same edge as a pop
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 16'h9000 + 16'(i), 8'(8'hC0 + i), 0, 0, 1);
    step(0, 16'h900F, 8'h00, 0, 0, 0);
    step(0, 16'h900F, 8'h00, 0, 0, 0);
    check("full_no_ovf_yet", overflow, 0);
    step(0, 16'h900F, 8'h00, 1, 0, 0);
    step(1, 16'h9010, 8'hEE, 1, 0, 1);
    step(0, 16'h9010, 8'h00, 1, 0, 0);
    check("full_pushpop_ovf", overflow, 0);
    wait_drain(80, "full");
    check("full_count", byte_count, 16'd17);
    check("full_checksum", checksum, model_sum);

    // Completion while three bytes are still queued
    do_reset();
    step(1, 16'h7000, 8'h10, 0, 0, 1);
    step(1, 16'h7001, 8'h20, 0, 0, 1);
    step(1, 16'h7002, 8'h30, 0, 0, 1);
    step(0, 16'h694D, 8'h00, 0, 1, 0);
    check("cmp_not_valid_early", exec_valid, 0);
    check("cmp_busy", busy, 1);
    ram_gnt = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (exec_valid) seen = 1'b1;
    end
    check("cmp_valid_seen", seen, 1);
    check("cmp_after_last_write", exp_q.size(), 0);
    check("cmp_writes", wr_seen, 3);
    check("cmp_exec_addr", exec_addr, 16'h694D);
    check("cmp_checksum", checksum, 8'h60);
    repeat (3) @(negedge clk);
    check("cmp_valid_hold", exec_valid, 1);
    @(posedge clk); #1;
    exec_ack = 1'b1;
    @(posedge clk); #1;
    exec_ack = 1'b0;
    check("cmp_valid_cleared", exec_valid, 0);
    check("cmp_idle", busy, 0);
    step(0, 16'h694D, 8'h00, 1, 0, 0);
    check("newload_count", byte_count, 0);
    check("newload_checksum", checksum, 0);

    // Asynchronous reset in the middle of a write
    do_reset();
    step(1, 16'hA000, 8'h77, 1, 0, 1);
    step(0, 16'hA000, 8'h00, 1, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ram_we) seen = 1'b1;
    end
    check("arst_write_seen", seen, 1);
    #1 reset_n = 1'b0;
    #1;
    check_all_zero("arst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete();
    model_count = 0;
    model_sum   = 8'd0;
    step(1, 16'hA100, 8'h42, 1, 0, 1);
    step(0, 16'hA100, 8'h00, 1, 0, 0);
    wait_drain(40, "arst_after");
    check("arst_after_count", byte_count, 16'd1);
    check("arst_after_checksum", checksum, 8'h42);

    // Randomized bursts checked against the queue model
    do_reset();
    for (int b = 0; b < 25; b++) begin
      len = $urandom_range(1, 16);
      captured = 0;
      guard = 0;
      while (captured < len && guard < 400) begin
        wr   = ($urandom_range(0, 3) != 0);
        addr = ($urandom_range(0, 2) == 0) ? prev_addr : 16'($urandom);
        data = 8'($urandom);
        gnt  = 1'($urandom_range(0, 1));
        cap  = wr && (!prev_wr || addr != prev_addr);
        step(wr, addr, data, gnt, 0, cap);
        captured += int'(cap);
        guard++;
      end
      step(0, prev_addr, 8'h00, 1, 0, 0);
      wait_drain(200, "rand");
      check("rand_count", byte_count, model_count);
      check("rand_checksum", checksum, model_sum);
      check("rand_no_ovf", overflow, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/tape_ram_writer.md
Name: tape_ram_writer

Overview:
- Downstream stage of the cassette TAP parser. It consumes the parser's tape_wr/tape_addr/tape_dout/tape_complete stream and commits each byte into Lynx main RAM through a request/grant port shared with the CPU.
- A small FIFO decouples parser byte timing from RAM availability.
- After the last byte is written, it hands the execution address to the boot/CPU-control logic through a valid/ack handshake.
- It also keeps a running byte count, an additive checksum and an overflow flag.

Parameters:
FIFO_DEPTH, 16, number of {addr,data} entries buffered; power of 2, minimum 2.
ADDR_W, 16, RAM address width.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
reset_n  in  1  asynchronous, active-low reset.
tape_wr  in  1  parser write-enable level; held high across consecutive bytes.
tape_addr  in  ADDR_W  parser target address; holds the exec address when tape_complete rises.
tape_dout  in  8  parser data byte.
tape_complete  in  1  parser load-finished level.
ram_req  out  1  RAM access request.
ram_gnt  in  1  RAM arbiter grant.
ram_addr  out  ADDR_W  RAM write address.
ram_dout  out  8  RAM write data.
ram_we  out  1  RAM write strobe, one cycle per byte.
busy  out  1  load activity in progress.
exec_valid  out  1  exec_addr is valid.
exec_addr  out  ADDR_W  execution start address.
exec_ack  in  1  consumer accepts exec_addr.
byte_count  out  16  bytes committed to RAM in the current load.
checksum  out  8  mod-256 sum of committed bytes.
overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, reset_n=0): FIFO empties; FSM goes to IDLE. All outputs go to 0: ram_req, ram_addr, ram_dout, ram_we, busy, exec_valid, exec_addr, byte_count, checksum, overflow. Registered input copies clear. A write in flight is abandoned, and ram_we falls immediately.
- Input registers: tape_wr_d, tape_addr_d and tape_complete_d are updated every cycle.
- Capture event: tape_wr=1 AND (tape_wr_d=0 OR tape_addr != tape_addr_d). On a capture event, {tape_addr,tape_dout} is pushed.
  - Data and address change on the same edge upstream, so they are sampled together.
- FIFO push rule: the push is accepted if the FIFO is not full, or if a pop occurs on the same edge. Otherwise the byte is dropped and overflow is set. overflow stays set until reset.
- Simultaneous push and pop: both take effect, and occupancy is unchanged.
- Pointers wrap modulo FIFO_DEPTH. The full/empty distinction uses an extra pointer bit.
- FSM states:
  - IDLE:
    - If the FIFO is non-empty, go to REQ and load ram_addr/ram_dout from the FIFO head.
    - Else if complete_pend=1, go to DONE.
  - REQ: ram_req=1. When ram_gnt is sampled high, go to WRITE.
  - WRITE: ram_req=1 and ram_we=1 for exactly one cycle. The head is popped on the exit edge, byte_count increments by 1 (wraps at 16 bits) and checksum adds ram_dout (mod 256).
    - Next state is REQ with the next head if entries remain, otherwise IDLE.
    - ram_gnt is ignored during WRITE, so a write always completes.
  - DONE: exec_valid=1 and exec_addr is held. When exec_ack is sampled high, clear exec_valid and complete_pend and go to IDLE.
- ram_addr/ram_dout are stable from REQ entry through the end of WRITE.
- Latency: capture edge N → FIFO non-empty after N → REQ entered at edge N+1 (ram_req high from then). With ram_gnt tied high: WRITE at N+2 and pop at N+3, giving a sustained rate of 1 byte per 2 cycles.
- Completion:
  - On tape_complete rising (tape_complete=1, tape_complete_d=0), set complete_pend and latch exec_addr<=tape_addr.
  - DONE is entered only once the FIFO is empty and the FSM is in IDLE, so every captured byte is written before exec_valid rises.
  - A tape_complete pulse while in DONE is ignored.
- New load: on tape_complete falling (tape_complete=0, tape_complete_d=1), clear byte_count and checksum. FIFO contents and overflow are untouched.
- busy = FIFO non-empty OR state != IDLE OR complete_pend. busy is combinational from registered state.

Test Plan:
- Reset, then 4 captures (addr 0x694D..0x6950, data 0x11,0x22,0x33,0x44) with ram_gnt=1 → 4 ram_we pulses at the same addr/data in order, 2 cycles apart; byte_count=4; checksum=0xAA.
- ram_gnt held 0 for 40 cycles while 20 bytes are captured (FIFO_DEPTH=16) → 16 stored, overflow=1. On grant, exactly 16 writes occur and byte_count=16.
- Push and pop on the same edge with the FIFO full → push accepted, overflow stays 0, all bytes written in order.
- tape_complete rises with tape_addr=0x694D while 3 bytes are still queued → exec_valid rises only after the 3rd ram_we, with exec_addr=0x694D. exec_ack for 1 cycle → exec_valid=0 and busy=0.
- tape_wr held high with tape_addr unchanged for 10 cycles → exactly 1 capture. tape_wr toggled 0→1 at the same addr → a second capture.
- reset_n asserted mid-WRITE → ram_we/ram_req fall asynchronously and all outputs read 0; after release, a new capture proceeds normally.
